// File: rtl/counter_driver.sv
// counter_driver: host queues LOAD/UP/DOWN/WAIT commands, FSM drives an up/down counter; first drive
// cycle lands 2 edges after the push, cmd_ready = !full. Macro CTRDRV_SAT_STOP_EN stops UP/DOWN at max/zero.
module counter_driver_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_vld,
  output logic          push_rdy,
  input  logic [DW-1:0] push_dat,
  input  logic          pop_en,
  output logic          pop_vld,
  output logic [DW-1:0] pop_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          push;
  logic          pop;

  // Ready comes only from the registered occupancy, so a full FIFO never accepts even when popping.
  assign push_rdy = (cnt != FULL_CNT);
  assign pop_vld  = (cnt != '0);
  assign pop_dat  = mem[rd_ptr];
  assign push     = push_vld & push_rdy;
  assign pop      = pop_en & pop_vld;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module counter_driver #(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic             load_n,
  output logic             ce,
  output logic             up_down,
  output logic [WIDTH-1:0] data_load,
  input  logic [WIDTH-1:0] count_out,
  input  logic             max_count,
  input  logic             zero,
  output logic             busy,
  output logic             done,
  output logic             sat
);
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_WAIT = 2'b11} op_t;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef struct packed {
    op_t              op;
    logic [WIDTH-1:0] arg;
  } cmd_t;

  cmd_t             cmd_in;
  cmd_t             head;
  logic             fifo_vld;
  logic             pop;
  state_t           state, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] rem, rem_d;
  logic [WIDTH-1:0] data_load_q, data_load_d;
  logic             load_n_q, load_n_d;
  logic             ce_q, ce_d;
  logic             up_down_q, up_down_d;
  logic             done_q, done_d;
  logic             sat_q, sat_d;
  logic             stop_q, stop_d;
  logic             hit;
  logic             stop_now;
  logic             unused_mon;

  assign cmd_in.op  = op_t'(cmd_op);
  assign cmd_in.arg = cmd_arg;

  counter_driver_fifo #(.DW($bits(cmd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (cmd_valid),
    .push_rdy (cmd_ready),
    .push_dat (cmd_in),
    .pop_en   (pop),
    .pop_vld  (fifo_vld),
    .pop_dat  (head)
  );

`ifdef CTRDRV_SAT_STOP_EN
  assign hit      = up_down_q ? max_count : zero;
  assign stop_now = ce_q & hit;
  assign ce       = ce_q & ~hit;
`else
  assign hit      = 1'b0;
  assign stop_now = 1'b0;
  assign ce       = ce_q;
`endif

  // Counter status is only acted on when stopping is enabled; count_out is for the host.
  assign unused_mon = ^{count_out, max_count, zero, hit};

  always_comb begin
    state_d     = state;
    op_d        = op_q;
    rem_d       = rem;
    load_n_d    = 1'b1;
    ce_d        = 1'b0;
    up_down_d   = up_down_q;
    data_load_d = data_load_q;
    done_d      = 1'b0;
    sat_d       = 1'b0;
    stop_d      = stop_q;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_vld) begin
          pop     = 1'b1;
          state_d = EXEC;
          op_d    = head.op;
          rem_d   = head.arg;
          stop_d  = 1'b0;
        end
      end
      EXEC: begin
        if (stop_now) begin
          state_d = DONE;
          stop_d  = 1'b1;
        end else begin
          case (op_q)
            OP_LOAD: begin
              load_n_d    = 1'b0;
              data_load_d = rem;
              state_d     = DONE;
            end
            OP_UP, OP_DOWN: begin
              if (rem == '0) begin
                state_d = DONE;
              end else begin
                ce_d      = 1'b1;
                up_down_d = (op_q == OP_UP);
                rem_d     = rem - 1'b1;
                if (rem == WIDTH'(1)) state_d = DONE;
              end
            end
            default: begin
              if (rem == '0) begin
                state_d = DONE;
              end else begin
                rem_d = rem - 1'b1;
                if (rem == WIDTH'(1)) state_d = DONE;
              end
            end
          endcase
        end
      end
      DONE: begin
        // A hit on the final UP/DOWN cycle still counts as an early stop.
        done_d  = 1'b1;
        sat_d   = stop_q | stop_now;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= OP_LOAD;
      rem         <= '0;
      load_n_q    <= 1'b1;
      ce_q        <= 1'b0;
      up_down_q   <= 1'b1;
      data_load_q <= '0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state       <= state_d;
      op_q        <= op_d;
      rem         <= rem_d;
      load_n_q    <= load_n_d;
      ce_q        <= ce_d;
      up_down_q   <= up_down_d;
      data_load_q <= data_load_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
      stop_q      <= stop_d;
    end
  end

  assign load_n    = load_n_q;
  assign up_down   = up_down_q;
  assign data_load = data_load_q;
  assign done      = done_q;
  assign sat       = sat_q;
  assign busy      = (state != IDLE) | fifo_vld;
endmodule
